// File: rtl/tone_meter.sv
// ---------------------------------------------------------------------------
// tone_meter
//
// Receive-side partner of the tonegen speaker block. It measures the
// half-period of a square wave on an input pin and reports the tonegen
// divider that would produce that tone. A result of 0 means the input is
// silent.
//
// The CPU reads results the same way it reads the console. The result is
// held on rd_data, and a one-cycle rd_re pulse consumes it.
//
// Parameters
//   TIMEOUT      cycles without an input edge before the input is declared
//                silent. Must be >= 4.
//   MATCH_COUNT  consecutive identical half-period measurements needed
//                before a result is published. Must be >= 1.
//
// Ports
//   clk       system clock
//   resetn    asynchronous active-low reset
//   sig_in    asynchronous square-wave input from the pin
//   rd_re     one-cycle pulse that consumes the current result
//   rd_data   published divider value (0 = silent)
//   rd_valid  an unread result is present
//   silent    no valid tone is present
//   overrun   a result was overwritten before it was read
// ---------------------------------------------------------------------------
module tone_meter #(
    parameter int unsigned TIMEOUT     = 2000000,
    parameter int unsigned MATCH_COUNT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sig_in,
    input  logic        rd_re,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        silent,
    output logic        overrun
);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
    localparam logic [31:0] MATCH_C   = 32'(MATCH_COUNT);

    logic        sync1;
    logic        sync2;
    logic        sync3;
    logic        pin_edge;

    state_t      state;
    state_t      state_next;
    logic [31:0] cnt;
    logic [31:0] cnt_next;
    logic [31:0] match;
    logic [31:0] match_next;
    logic [31:0] last_cand;
    logic [31:0] last_cand_next;
    logic [31:0] cand;

    logic        publish;
    logic        publish_timeout;
    logic [31:0] publish_value;

    // Pin synchronizer. The third flop only serves edge detection: a change
    // on either polarity is one tonegen half-period boundary. Every edge is
    // delayed by the same amount, so measured intervals are exact.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign pin_edge = sync2 ^ sync3;

    // tonegen with divider D toggles every D+2 cycles. The candidate divider
    // is therefore the interval minus two. It is only used when the interval
    // is at least 2.
    assign cand = cnt - 32'd2;

    // Measurement state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= 32'd0;
            match     <= 32'd0;
            last_cand <= 32'd0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            match     <= match_next;
            last_cand <= last_cand_next;
        end
    end

    // Next-state logic and the qualification of measurements.
    // A result is published only on the cycle where the match run first
    // reaches MATCH_COUNT, so a steady tone publishes exactly once.
    // An edge takes priority over the timeout check.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        match_next      = match;
        last_cand_next  = last_cand;
        publish         = 1'b0;
        publish_timeout = 1'b0;
        publish_value   = 32'd0;

        case (state)
            IDLE: begin
                if (pin_edge) begin
                    state_next = COUNT;
                    cnt_next   = 32'd1;
                end
            end

            COUNT: begin
                if (pin_edge) begin
                    cnt_next = 32'd1;
                    if (cnt < 32'd2) begin
                        // Glitch: the interval is too short to be a tonegen tone.
                        match_next = 32'd0;
                    end else if ((cand == last_cand) && (match != 32'd0)) begin
                        if (match >= MATCH_C) begin
                            match_next = MATCH_C;
                        end else begin
                            match_next = match + 32'd1;
                        end
                        if ((match != MATCH_C) && (match_next == MATCH_C)) begin
                            publish       = 1'b1;
                            publish_value = cand;
                        end
                    end else begin
                        last_cand_next = cand;
                        match_next     = 32'd1;
                        if (MATCH_C == 32'd1) begin
                            publish       = 1'b1;
                            publish_value = cand;
                        end
                    end
                end else if (cnt >= TIMEOUT_C) begin
                    state_next     = IDLE;
                    cnt_next       = 32'd0;
                    match_next     = 32'd0;
                    last_cand_next = 32'd0;
                    // Going silent is reported once. Later timeouts stay quiet.
                    if (!silent) begin
                        publish         = 1'b1;
                        publish_timeout = 1'b1;
                        publish_value   = 32'd0;
                    end
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // CPU-facing result register.
    // A publish overrides a simultaneous rd_re: the new value is unread and
    // nothing was lost. An overrun is flagged only when an unread value is
    // replaced without being consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data  <= 32'd0;
            rd_valid <= 1'b0;
            silent   <= 1'b1;
            overrun  <= 1'b0;
        end else if (publish) begin
            rd_data  <= publish_value;
            rd_valid <= 1'b1;
            silent   <= publish_timeout;
            overrun  <= rd_valid & ~rd_re;
        end else if (rd_re) begin
            rd_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tone_meter.sv
// ---------------------------------------------------------------------------
// tb_tone_meter
//
// Directed, self-checking bench for tone_meter. It uses a shortened TIMEOUT
// so the run stays short.
//
// All stimulus is driven and all outputs are sampled 1 time unit after a
// rising clock edge. A pin toggle made after edge k is seen as an edge
// at edge k+3, so its publish is visible after the third following tick.
// ---------------------------------------------------------------------------
module tb_tone_meter;

    localparam int unsigned TIMEOUT     = 8100;
    localparam int unsigned MATCH_COUNT = 2;

    logic        clk;
    logic        resetn;
    logic        sig_in;
    logic        rd_re;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        silent;
    logic        overrun;

    int checks;
    int fails;

    tone_meter #(
        .TIMEOUT     (TIMEOUT),
        .MATCH_COUNT (MATCH_COUNT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .sig_in   (sig_in),
        .rd_re    (rd_re),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .silent   (silent),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic toggle();
        sig_in = ~sig_in;
    endtask

    task automatic pulse_rd();
        rd_re = 1'b1;
        tick(1);
        rd_re = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        sig_in = 1'b0;
        rd_re  = 1'b0;
        tick(3);
        checks++; if (rd_data !== 32'd0) begin fails++; $display("[TB] FAIL reset_data: got %0d expected 0", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", rd_valid); end
        checks++; if (silent !== 1'b1) begin fails++; $display("[TB] FAIL reset_silent: got %b expected 1", silent); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        resetn = 1'b1;
        tick(2);
    endtask

    // D=8000 tone: toggle every 8002 cycles; publish after the third edge.
    task automatic test_steady_tone();
        toggle();
        tick(8002); toggle();
        tick(5);
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL steady_early: got valid %b expected 0", rd_valid); end
        tick(8002 - 5); toggle();
        tick(4);
        checks++; if (rd_valid !== 1'b1) begin fails++; $display("[TB] FAIL steady_valid: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== 32'd8000) begin fails++; $display("[TB] FAIL steady_data: got %0d expected 8000", rd_data); end
        checks++; if (silent !== 1'b0) begin fails++; $display("[TB] FAIL steady_silent: got %b expected 0", silent); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL steady_overrun: got %b expected 0", overrun); end
        pulse_rd();
        tick(8002 - 5); toggle();
        tick(5);
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL steady_repub: got valid %b expected 0", rd_valid); end
        checks++; if (rd_data !== 32'd8000) begin fails++; $display("[TB] FAIL steady_hold: got %0d expected 8000", rd_data); end
    endtask

    // Hold the pin constant; the timeout publishes 0 once.
    task automatic test_silence();
        pulse_rd();
        tick(TIMEOUT - 16);
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL silence_early: got valid %b expected 0", rd_valid); end
        checks++; if (silent !== 1'b0) begin fails++; $display("[TB] FAIL silence_early_silent: got %b expected 0", silent); end
        tick(20);
        checks++; if (rd_valid !== 1'b1) begin fails++; $display("[TB] FAIL silence_valid: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== 32'd0) begin fails++; $display("[TB] FAIL silence_data: got %0d expected 0", rd_data); end
        checks++; if (silent !== 1'b1) begin fails++; $display("[TB] FAIL silence_silent: got %b expected 1", silent); end
        pulse_rd();
        tick(TIMEOUT + 20);
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL silence_repub: got valid %b expected 0", rd_valid); end
        checks++; if (silent !== 1'b1) begin fails++; $display("[TB] FAIL silence_hold: got %b expected 1", silent); end
    endtask

    // Intervals 100, 101, 101 give candidates 98, 99, 99, which publishes 99.
    task automatic test_jitter();
        toggle();
        tick(100); toggle();
        tick(101); toggle();
        tick(5);
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL jitter_pair: got valid %b expected 0", rd_valid); end
        tick(96); toggle();
        tick(4);
        checks++; if (rd_valid !== 1'b1) begin fails++; $display("[TB] FAIL jitter_valid: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== 32'd99) begin fails++; $display("[TB] FAIL jitter_data: got %0d expected 99", rd_data); end
        checks++; if (silent !== 1'b0) begin fails++; $display("[TB] FAIL jitter_silent: got %b expected 0", silent); end
        pulse_rd();
        tick(97); toggle();
        tick(5);
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL jitter_single: got valid %b expected 0", rd_valid); end
        checks++; if (rd_data !== 32'd99) begin fails++; $display("[TB] FAIL jitter_hold: got %0d expected 99", rd_data); end
    endtask

    // Tests overrun and the read handshake, including rd_re in the same
    // cycle as a publish.
    task automatic test_overrun();
        tick(497); toggle();
        tick(502); toggle();
        tick(4);
        checks++; if (rd_data !== 32'd500) begin fails++; $display("[TB] FAIL ovr_first_data: got %0d expected 500", rd_data); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL ovr_first_flag: got %b expected 0", overrun); end
        tick(298); toggle();
        tick(302); toggle();
        tick(4);
        checks++; if (rd_data !== 32'd300) begin fails++; $display("[TB] FAIL ovr_second_data: got %0d expected 300", rd_data); end
        checks++; if (overrun !== 1'b1) begin fails++; $display("[TB] FAIL ovr_second_flag: got %b expected 1", overrun); end
        checks++; if (rd_valid !== 1'b1) begin fails++; $display("[TB] FAIL ovr_second_valid: got %b expected 1", rd_valid); end
        pulse_rd();
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL ovr_read_valid: got %b expected 0", rd_valid); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL ovr_read_flag: got %b expected 0", overrun); end
        checks++; if (rd_data !== 32'd300) begin fails++; $display("[TB] FAIL ovr_read_data: got %0d expected 300", rd_data); end
        tick(397); toggle();
        tick(402); toggle();
        tick(4);
        checks++; if (rd_data !== 32'd400) begin fails++; $display("[TB] FAIL ovr_third_data: got %0d expected 400", rd_data); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL ovr_third_flag: got %b expected 0", overrun); end
        tick(698); toggle();
        tick(702); toggle();
        tick(2);
        rd_re = 1'b1;
        tick(1);
        rd_re = 1'b0;
        checks++; if (rd_valid !== 1'b1) begin fails++; $display("[TB] FAIL ovr_race_valid: got %b expected 1", rd_valid); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL ovr_race_flag: got %b expected 0", overrun); end
        checks++; if (rd_data !== 32'd700) begin fails++; $display("[TB] FAIL ovr_race_data: got %0d expected 700", rd_data); end
    endtask

    // Asynchronous reset during a D=8000 tone that already has one matching
    // interval. A fresh start needs three new edges.
    task automatic test_reset_mid();
        tick(47); toggle();
        tick(8002); toggle();
        tick(4000);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_data !== 32'd0) begin fails++; $display("[TB] FAIL rstmid_data: got %0d expected 0", rd_data); end
        checks++; if (silent !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_silent: got %b expected 1", silent); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_overrun: got %b expected 0", overrun); end
        sig_in = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(2);
        toggle();
        tick(8002); toggle();
        tick(5);
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_early: got valid %b expected 0", rd_valid); end
        tick(7997); toggle();
        tick(4);
        checks++; if (rd_valid !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_pub_valid: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== 32'd8000) begin fails++; $display("[TB] FAIL rstmid_pub_data: got %0d expected 8000", rd_data); end
        checks++; if (silent !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_pub_silent: got %b expected 0", silent); end
    endtask

    // Toggling every cycle produces only sub-2 intervals, so nothing publishes.
    task automatic test_glitch();
        resetn = 1'b0;
        sig_in = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(1);
        for (int i = 0; i < 50; i++) begin
            toggle();
            tick(1);
            checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL glitch_valid[%0d]: got %b expected 0", i, rd_valid); end
        end
        tick(10);
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL glitch_final_valid: got %b expected 0", rd_valid); end
        checks++; if (silent !== 1'b1) begin fails++; $display("[TB] FAIL glitch_silent: got %b expected 1", silent); end
        checks++; if (rd_data !== 32'd0) begin fails++; $display("[TB] FAIL glitch_data: got %0d expected 0", rd_data); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_steady_tone();
        test_silence();
        test_jitter();
        test_overrun();
        test_reset_mid();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
